imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 127 ++++++++++++
 tb/tb_imm_encoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline that places a 32-bit immediate
// into the immediate-carrying bits [31:7] of an instruction word for the
// selected format (I, S, B, J, U, shift). It also flags values that the
// format cannot represent exactly.
//
// Ports
//   CLK           rising-edge clock for all state
//   RST           synchronous active-low reset
//   InValid       request valid
//   InReady       request accepted on InValid && InReady at a rising edge
//   ImmIn         two's-complement immediate to encode
//   ImmSrcIn      format: 0 I, 1 S, 2 B, 3 J, 4 U, 5 shift, 6/7 as I
//   OutValid      result valid
//   OutReady      result consumed on OutValid && OutReady at a rising edge
//   ImmFieldsOut  instruction bits [31:7]; bit 24 is instruction bit 31
//   RangeErr      ImmIn not representable in the format (qualified by OutValid)
//   ErrCount      saturating count of consumed results with RangeErr set
module imm_encoder (
   input  logic        CLK,
   input  logic        RST,
   input  logic        InValid,
   output logic        InReady,
   input  logic [31:0] ImmIn,
   input  logic [2:0]  ImmSrcIn,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [24:0] ImmFieldsOut,
   output logic        RangeErr,
   output logic [7:0]  ErrCount
);

   localparam logic [2:0] FMT_S  = 3'd1;
   localparam logic [2:0] FMT_B  = 3'd2;
   localparam logic [2:0] FMT_J  = 3'd3;
   localparam logic [2:0] FMT_U  = 3'd4;
   localparam logic [2:0] FMT_SH = 3'd5;

   logic        s1_valid;
   logic [31:0] s1_imm;
   logic [2:0]  s1_src;

   logic        s2_adv;
   logic        s1_accept;

   logic [31:7] enc_inst;
   logic        enc_err;

   // S2 moves whenever its slot is empty or being drained; S1 can take a new
   // request when empty or when its content moves into S2 on the same edge.
   assign s2_adv    = !OutValid || OutReady;
   assign s1_accept = !s1_valid || s2_adv;
   assign InReady   = RST && s1_accept;

   // Encoder between S1 and S2. Bits not carrying an immediate stay 0; on a
   // range error the truncated encoding is still produced.
   always_comb begin
      enc_inst = '0;
      enc_err  = 1'b0;
      case (s1_src)
         FMT_S: begin
            enc_inst[31:25] = s1_imm[11:5];
            enc_inst[11:7]  = s1_imm[4:0];
            enc_err = (s1_imm != {{20{s1_imm[11]}}, s1_imm[11:0]});
         end
         FMT_B: begin
            enc_inst[31]    = s1_imm[12];
            enc_inst[30:25] = s1_imm[10:5];
            enc_inst[11:8]  = s1_imm[4:1];
            enc_inst[7]     = s1_imm[11];
            enc_err = s1_imm[0] ||
                      (s1_imm != {{19{s1_imm[12]}}, s1_imm[12:0]});
         end
         FMT_J: begin
            enc_inst[31]    = s1_imm[20];
            enc_inst[30:21] = s1_imm[10:1];
            enc_inst[20]    = s1_imm[11];
            enc_inst[19:12] = s1_imm[19:12];
            enc_err = s1_imm[0] ||
                      (s1_imm != {{11{s1_imm[20]}}, s1_imm[20:0]});
         end
         FMT_U: begin
            enc_inst[31:12] = s1_imm[31:12];
            enc_err = (s1_imm[11:0] != 12'd0);
         end
         FMT_SH: begin
            enc_inst[24:20] = s1_imm[4:0];
            enc_err = (s1_imm[31:5] != 27'd0);
         end
         default: begin
            // I format, also used for the two unassigned codes
            enc_inst[31:20] = s1_imm[11:0];
            enc_err = (s1_imm != {{20{s1_imm[11]}}, s1_imm[11:0]});
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         s1_valid     <= 1'b0;
         s1_imm       <= '0;
         s1_src       <= '0;
         OutValid     <= 1'b0;
         ImmFieldsOut <= '0;
         RangeErr     <= 1'b0;
         ErrCount     <= '0;
      end else begin
         if (s1_accept) begin
            s1_valid <= InValid;
            if (InValid) begin
               s1_imm <= ImmIn;
               s1_src <= ImmSrcIn;
            end
         end
         if (s2_adv) begin
            OutValid <= s1_valid;
            if (s1_valid) begin
               ImmFieldsOut <= enc_inst;
               RangeErr     <= enc_err;
            end
         end
         if (OutValid && OutReady && RangeErr && (ErrCount != 8'hFF)) begin
            ErrCount <= ErrCount + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

   logic        CLK = 1'b0;
   logic        RST;
   logic        InValid;
   logic        InReady;
   logic [31:0] ImmIn;
   logic [2:0]  ImmSrcIn;
   logic        OutValid;
   logic        OutReady;
   logic [24:0] ImmFieldsOut;
   logic        RangeErr;
   logic [7:0]  ErrCount;

   imm_encoder dut (
      .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady),
      .ImmIn(ImmIn), .ImmSrcIn(ImmSrcIn), .OutValid(OutValid),
      .OutReady(OutReady), .ImmFieldsOut(ImmFieldsOut),
      .RangeErr(RangeErr), .ErrCount(ErrCount)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Which immediate bit lands on instruction bit ib for format t (-1: none).
   function automatic int srcbit(input int t, input int ib);
      case (t)
         1: return (ib >= 25) ? ib - 20 : (ib <= 11) ? ib - 7 : -1;
         2: begin
            if (ib == 31) return 12;
            if (ib >= 25) return ib - 20;
            if (ib >= 8 && ib <= 11) return ib - 7;
            if (ib == 7) return 11;
            return -1;
         end
         3: begin
            if (ib == 31) return 20;
            if (ib >= 21) return ib - 20;
            if (ib == 20) return 11;
            if (ib >= 12) return ib;
            return -1;
         end
         4: return (ib >= 12) ? ib : -1;
         5: return (ib >= 20 && ib <= 24) ? ib - 20 : -1;
         default: return (ib >= 20) ? ib - 20 : -1;
      endcase
   endfunction

   // Reference: range rules as integer intervals, fields via the bit map.
   function automatic void model(input logic [2:0] s, input logic [31:0] v,
                                 output logic [24:0] f, output logic e);
      longint x;
      int t, k;
      x = $signed(v);
      t = (s > 3'd5) ? 0 : int'(s);
      case (t)
         2: e = v[0] || (x < -4096) || (x > 4095);
         3: e = v[0] || (x < -1048576) || (x > 1048575);
         4: e = (v % 32'd4096) != 0;
         5: e = v > 32'd31;
         default: e = (x < -2048) || (x > 2047);
      endcase
      f = '0;
      for (int ib = 7; ib < 32; ib++) begin
         k = srcbit(t, ib);
         if (k >= 0) f[ib-7] = v[k];
      end
   endfunction

   // Independent immediate-extension decode used for the round-trip property.
   function automatic logic [31:0] decode(input logic [2:0] s,
                                          input logic [24:0] f);
      logic [31:0] inst;
      inst = {f, 7'b0};
      case (s)
         3'd1: return {{20{inst[31]}}, inst[31:25], inst[11:7]};
         3'd2: return {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                       inst[11:8], 1'b0};
         3'd3: return {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                       inst[30:21], 1'b0};
         3'd4: return {inst[31:12], 12'b0};
         3'd5: return {27'b0, inst[24:20]};
         default: return {{20{inst[31]}}, inst[31:20]};
      endcase
   endfunction

   typedef struct {
      logic [2:0]  s;
      logic [31:0] v;
      logic [24:0] f;
      logic        e;
   } item_t;

   item_t q[$];
   int    errm = 0;
   logic  prev_stall = 1'b0;
   logic [24:0] pf;
   logic  pe;

   // Scoreboard / monitor, sampled on the falling edge.
   always @(negedge CLK) begin
      item_t it;
      if (!RST) begin
         check("inready_in_reset", {31'b0, InReady}, 32'd0);
         q.delete();
         errm = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", {31'b0, OutValid}, 32'd1);
            check("hold_fields", {7'b0, ImmFieldsOut}, {7'b0, pf});
            check("hold_err", {31'b0, RangeErr}, {31'b0, pe});
         end
         check("errcount", {24'b0, ErrCount}, errm);
         if (OutValid && OutReady) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=%h required=none", ImmFieldsOut);
            end else begin
               it = q.pop_front();
               check("fields", {7'b0, ImmFieldsOut}, {7'b0, it.f});
               check("rangeerr", {31'b0, RangeErr}, {31'b0, it.e});
               if (!it.e) check("roundtrip", decode(it.s, ImmFieldsOut), it.v);
               if (it.e && errm < 255) errm++;
            end
         end
         if (InValid && InReady) begin
            it.s = ImmSrcIn;
            it.v = ImmIn;
            model(ImmSrcIn, ImmIn, it.f, it.e);
            q.push_back(it);
         end
         prev_stall = OutValid && !OutReady;
         pf = ImmFieldsOut;
         pe = RangeErr;
      end
   end

   task automatic send(input logic [2:0] s, input logic [31:0] v);
      int n;
      n = 0;
      InValid = 1'b1;
      ImmSrcIn = s;
      ImmIn = v;
      @(negedge CLK);
      while (!InReady && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!InReady) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=InReady low required=accept");
      end
      @(posedge CLK);
      #1;
      InValid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      check("drain", q.size(), 32'd0);
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] rand_imm();
      case ($urandom % 5)
         0: return $urandom;
         1: return 32'($urandom_range(0, 8191)) - 32'd4096;
         2: return {{11{1'b0}}, 21'($urandom)} - 32'h0010_0000;
         3: return 32'($urandom_range(0, 40));
         default: return {20'($urandom), 12'($urandom % 2 ? 0 : $urandom)};
      endcase
   endfunction

   typedef struct {
      logic [2:0]  s;
      logic [31:0] v;
      logic [24:0] f;
      logic        e;
   } vec_t;

   vec_t tv[13];

   initial begin
      int n;
      tv[0]  = '{3'd0, 32'hFFFF_F800, 25'h100_0000, 1'b0};
      tv[1]  = '{3'd2, 32'h0000_0FFE, 25'h0FC_001F, 1'b0};
      tv[2]  = '{3'd2, 32'h0000_0FFF, 25'h0FC_001F, 1'b1};
      tv[3]  = '{3'd2, 32'h0000_1000, 25'h100_0000, 1'b1};
      tv[4]  = '{3'd5, 32'h0000_0020, 25'h000_0000, 1'b1};
      tv[5]  = '{3'd4, 32'h1234_5000, 25'h024_68A0, 1'b0};
      tv[6]  = '{3'd0, 32'h0000_07FF, 25'h0FF_E000, 1'b0};
      tv[7]  = '{3'd0, 32'h0000_0800, 25'h100_0000, 1'b1};
      tv[8]  = '{3'd1, 32'hFFFF_FFFF, 25'h1FC_001F, 1'b0};
      tv[9]  = '{3'd3, 32'h000F_FFFE, 25'h0FF_FFE0, 1'b0};
      tv[10] = '{3'd6, 32'h0000_0005, 25'h000_A000, 1'b0};
      tv[11] = '{3'd5, 32'h0000_001F, 25'h003_E000, 1'b0};
      tv[12] = '{3'd4, 32'h0000_0001, 25'h000_0000, 1'b1};

      RST = 1'b0;
      InValid = 1'b0;
      ImmIn = '0;
      ImmSrcIn = '0;
      OutReady = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_outvalid", {31'b0, OutValid}, 32'd0);
      check("rst_fields", {7'b0, ImmFieldsOut}, 32'd0);
      check("rst_err", {31'b0, RangeErr}, 32'd0);
      check("rst_errcount", {24'b0, ErrCount}, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(negedge CLK);
      check("inready_after_rst", {31'b0, InReady}, 32'd1);
      @(posedge CLK);
      #1;

      // Directed vectors, one at a time with latency check.
      for (int i = 0; i < 13; i++) begin
         send(tv[i].s, tv[i].v);
         n = 0;
         while (1) begin
            @(negedge CLK);
            n++;
            if (OutValid || n >= 20) break;
         end
         check("latency", n, 32'd2);
         check("vec_fields", {7'b0, ImmFieldsOut}, {7'b0, tv[i].f});
         check("vec_err", {31'b0, RangeErr}, {31'b0, tv[i].e});
         @(posedge CLK);
         #1;
      end

      // Backpressure: two accepted, third held while output stalls.
      OutReady = 1'b0;
      send(3'd0, 32'h0000_0123);
      send(3'd2, 32'hFFFF_F000);
      InValid = 1'b1;
      ImmSrcIn = 3'd3;
      ImmIn = 32'h0000_0003;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("bp_inready_low", {31'b0, InReady}, 32'd0);
         check("bp_outvalid", {31'b0, OutValid}, 32'd1);
      end
      @(posedge CLK);
      #1;
      OutReady = 1'b1;
      send(3'd3, 32'h0000_0003);
      drain();

      // Reset with two requests in flight.
      OutReady = 1'b0;
      send(3'd5, 32'h0000_0040);
      send(3'd5, 32'h0000_0080);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      OutReady = 1'b1;
      @(negedge CLK);
      check("midrst_outvalid", {31'b0, OutValid}, 32'd0);
      check("midrst_errcount", {24'b0, ErrCount}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("midrst_no_stale", {31'b0, OutValid}, 32'd0);
      end
      @(posedge CLK);
      #1;

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 800; i++) begin
         InValid = ($urandom % 3) != 0;
         ImmSrcIn = 3'($urandom % 8);
         ImmIn = rand_imm();
         OutReady = ($urandom % 4) != 0;
         @(posedge CLK);
         #1;
      end
      InValid = 1'b0;
      OutReady = 1'b1;
      drain();

      // Error counter saturation.
      for (int i = 0; i < 300; i++) send(3'd5, 32'h0000_0020);
      drain();
      check("errcount_sat", {24'b0, ErrCount}, 32'd255);
      for (int i = 0; i < 5; i++) send(3'd2, 32'h0000_0001);
      drain();
      check("errcount_stays_sat", {24'b0, ErrCount}, 32'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
